// File: rtl/ram_scan_reader_if.sv
// Bus between ram_scan_reader and its surroundings: control inputs, RAM port and display outputs.
interface ram_scan_reader_if;
    logic       start;
    logic       stop;
    logic       continuous;
    logic [4:0] mem_address;
    logic       mem_wren;
    logic [3:0] mem_q;
    logic [4:0] addr_out;
    logic [3:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic [8:0] checksum_out;
    logic       checksum_valid;

    modport slave (
        input  start, stop, continuous, mem_q,
        output mem_address, mem_wren, addr_out, data_out, data_valid,
               busy, done, checksum_out, checksum_valid
    );

    modport master (
        output start, stop, continuous, mem_q,
        input  mem_address, mem_wren, addr_out, data_out, data_valid,
               busy, done, checksum_out, checksum_valid
    );
endinterface

// File: rtl/ram_scan_reader.sv
// Sweeps a 32x4 RAM, showing each word for TICK_COUNT clocks.
// Define RAM_SCAN_READER_CHECKSUM_EN to enable the per-sweep checksum accumulator.
module ram_scan_reader #(
    parameter int TICK_COUNT = 50000000
) (
    input logic            clock,
    input logic            reset,
    ram_scan_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, HOLD} state_t;

    localparam logic [25:0] HOLD_LOAD = 26'(TICK_COUNT - 1);

    state_t      state;
    logic [25:0] hold_cnt;
    logic [4:0]  addr;
    logic [3:0]  data;
    logic        data_valid;
    logic        busy;
    logic        done;

    wire hold_end  = (state == HOLD) && (hold_cnt == 26'd0);
    wire sweep_go  = (state == IDLE) && bus.start && !bus.stop;
    wire abort     = (state != IDLE) && bus.stop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= 26'd0;
            addr       <= 5'd0;
            data       <= 4'd0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                addr     <= 5'd0;
                busy     <= 1'b0;
                hold_cnt <= 26'd0;
            end else begin
                case (state)
                    IDLE: if (sweep_go) begin
                        state <= ADDR;
                        addr  <= 5'd0;
                        busy  <= 1'b1;
                    end
                    ADDR:  state <= WAIT;
                    WAIT:  state <= LATCH;
                    LATCH: begin
                        state      <= HOLD;
                        data       <= bus.mem_q;
                        data_valid <= 1'b1;
                        hold_cnt   <= HOLD_LOAD;
                    end
                    HOLD: if (hold_cnt == 26'd0) begin
                        if (addr != 5'd31) begin
                            addr  <= addr + 5'd1;
                            state <= ADDR;
                        end else begin
                            done <= 1'b1;
                            addr <= 5'd0;
                            if (bus.continuous) begin
                                state <= ADDR;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 26'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RAM_SCAN_READER_CHECKSUM_EN
    logic [8:0] csum;
    logic       csum_valid;

    // On a wrap the sum restarts at the first capture, so the finished total stays visible with done.
    always_ff @(posedge clock) begin
        if (reset) begin
            csum       <= 9'd0;
            csum_valid <= 1'b0;
        end else begin
            csum_valid <= 1'b0;
            if (sweep_go) begin
                csum <= 9'd0;
            end else if (state == LATCH && !bus.stop) begin
                csum <= ((addr == 5'd0) ? 9'd0 : csum) + {5'd0, bus.mem_q};
            end
            if (hold_end && !bus.stop && addr == 5'd31) csum_valid <= 1'b1;
        end
    end

    assign bus.checksum_out   = csum;
    assign bus.checksum_valid = csum_valid;
`else
    assign bus.checksum_out   = 9'd0;
    assign bus.checksum_valid = 1'b0;
`endif

    assign bus.mem_address = addr;
    assign bus.mem_wren    = 1'b0;
    assign bus.addr_out    = addr;
    assign bus.data_out    = data;
    assign bus.data_valid  = data_valid;
    assign bus.busy        = busy;
    assign bus.done        = done;
endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with TICK_COUNT=4 and a RAM holding mem[i]=i mod 16.
module tb_ram_scan_reader;
    localparam int T = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_scan_reader_if bus();
    ram_scan_reader #(.TICK_COUNT(T)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [3:0] mem [32];
    always @(posedge clock) bus.mem_q <= mem[bus.mem_address];

    int errors = 0;
    int checks = 0;

`ifdef RAM_SCAN_READER_CHECKSUM_EN
    localparam int EXP_CSUM = 240;
    localparam int EXP_CVLD = 1;
`else
    localparam int EXP_CSUM = 0;
    localparam int EXP_CVLD = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_dv(input int bound, output int waited);
        waited = 0;
        while (!bus.data_valid && waited < bound) begin
            tick(1);
            waited++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"}, 32'(bus.addr_out), 0);
        check({tag, "_mem_address"}, 32'(bus.mem_address), 0);
        check({tag, "_data"}, 32'(bus.data_out), 0);
        check({tag, "_dv"}, 32'(bus.data_valid), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_csum"}, 32'(bus.checksum_out), 0);
        check({tag, "_cvld"}, 32'(bus.checksum_valid), 0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        int w, n_dv, n_done, cyc, last_addr, last_data, seen_dv, seen_busy;
        for (int i = 0; i < 32; i++) mem[i] = 4'(i % 16);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.continuous = 1'b0;

        // reset state
        tick(2);
        check_reset_vals("rst");
        check("wren", 32'(bus.mem_wren), 0);
        reset = 1'b0;
        tick(1);

        // single sweep: latency, spacing, data, done
        pulse_start();
        check("busy_start", 32'(bus.busy), 1);
        tick(2);
        check("lat_early", 32'(bus.data_valid), 0);
        tick(1);
        check("latency", 32'(bus.data_valid), 1);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) begin
                tick(1);
                wait_dv(20, w);
                check("gap", 32'(w + 1), 7);
            end
            check("sweep_addr", 32'(bus.addr_out), 32'(i));
            check("sweep_data", 32'(bus.data_out), 32'(i % 16));
        end
        tick(4);
        check("done", 32'(bus.done), 1);
        check("done_busy", 32'(bus.busy), 0);
        check("done_addr", 32'(bus.addr_out), 0);
        check("csum", 32'(bus.checksum_out), 32'(EXP_CSUM));
        check("cvld", 32'(bus.checksum_valid), 32'(EXP_CVLD));
        tick(1);
        check("done_pulse", 32'(bus.done), 0);
        check("data_held", 32'(bus.data_out), 15);
        check("csum_held", 32'(bus.checksum_out), 32'(EXP_CSUM));

        // continuous: wrap back to address 0
        bus.continuous = 1'b1;
        pulse_start();
        n_dv = 0; n_done = 0; cyc = 0; last_addr = 99; last_data = 99;
        while (n_dv < 33 && cyc < 33 * 7 + 30) begin
            tick(1);
            cyc++;
            if (bus.done) n_done++;
            if (bus.data_valid) begin
                n_dv++;
                last_addr = int'(bus.addr_out);
                last_data = int'(bus.data_out);
            end
        end
        check("cont_dv_count", 32'(n_dv), 33);
        check("cont_done_count", 32'(n_done), 1);
        check("wrap_addr", 32'(last_addr), 0);
        check("wrap_data", 32'(last_data), 0);
        check("cont_busy", 32'(bus.busy), 1);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        bus.continuous = 1'b0;
        check("cont_stop_busy", 32'(bus.busy), 0);

        // stop during HOLD at address 10
        pulse_start();
        cyc = 0;
        while (!(bus.data_valid && bus.addr_out == 5'd10) && cyc < 120) begin
            tick(1);
            cyc++;
        end
        check("reach_a10", 32'(bus.addr_out), 10);
        tick(1);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("stop_busy", 32'(bus.busy), 0);
        check("stop_addr", 32'(bus.addr_out), 0);
        check("stop_data", 32'(bus.data_out), 10);
        check("stop_done", 32'(bus.done), 0);
        seen_dv = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.data_valid) seen_dv++;
        end
        check("stop_no_dv", 32'(seen_dv), 0);
        check("stop_data_kept", 32'(bus.data_out), 10);

        // start and stop together in IDLE
        bus.start = 1'b1;
        bus.stop = 1'b1;
        seen_dv = 0; seen_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.data_valid) seen_dv++;
            if (bus.busy) seen_busy++;
        end
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check("both_busy", 32'(seen_busy), 0);
        check("both_dv", 32'(seen_dv), 0);

        // reset during WAIT
        pulse_start();
        tick(1);
        check("wait_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        tick(1);
        check_reset_vals("rst_wait");
        reset = 1'b0;
        tick(1);

        // start held across done restarts on the edge after IDLE entry
        bus.start = 1'b1;
        cyc = 0;
        while (!bus.done && cyc < 32 * 7 + 20) begin
            tick(1);
            cyc++;
        end
        check("held_done", 32'(bus.done), 1);
        check("held_idle", 32'(bus.busy), 0);
        tick(1);
        check("held_restart", 32'(bus.busy), 1);
        bus.start = 1'b0;
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("held_stop", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
